// File: rtl/reg_load_ctrl_pkg.sv
// Shared types and defaults for the register-bank load controller.
package reg_load_ctrl_pkg;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_LOAD,
    S_DONE,
    S_ERR
  } state_e;

  localparam int NREG_DEF    = 6;
  localparam int TIMEOUT_DEF = 15;
  localparam int IDX_W_DEF   = cnt_w(NREG_DEF);
  localparam int TMR_W_DEF   = cnt_w(TIMEOUT_DEF + 1);

endpackage

// File: rtl/reg_load_ctrl_timer.sv
// Counts consecutive unacknowledged request cycles; expired flags the TIMEOUT-th one.
module wait_timer
  import reg_load_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CW = cnt_w(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_cnt <= '0;
    else if (clr)    r_cnt <= '0;
    else if (inc)    r_cnt <= r_cnt + CW'(1);
  end

  // Combinational so the FSM leaves REQ on the same edge that counts the last cycle.
  assign expired = inc && (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/reg_load_ctrl.sv
// Walks a bus read over NREG byte registers and loads each into the bank one-hot.
module reg_load_ctrl
  import reg_load_ctrl_pkg::*;
#(
  parameter int          NREG      = NREG_DEF,
  parameter logic [7:0]  BASE_ADDR = 8'h00,
  parameter int          TIMEOUT   = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            clear_req,
  input  logic            rd_ack,
  input  logic [7:0]      data_in,
  output logic            rd_req,
  output logic [7:0]      addr,
  output logic [NREG-1:0] en,
  output logic [7:0]      data_out,
  output logic            clr,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int IDX_W = cnt_w(NREG);

  state_e            r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [7:0]        r_cap;
  logic [7:0]        r_addr;
  logic              r_rd_req;
  logic [NREG-1:0]   r_en;
  logic              r_busy;
  logic              r_done;
  logic              r_clr;
  logic              r_err;

  logic              w_expired;
  logic              w_tmr_clr;
  logic              w_tmr_inc;
  logic [IDX_W-1:0]  w_idx_inc;
  logic [NREG-1:0]   w_onehot;

  assign w_idx_inc = r_idx + IDX_W'(1);
  assign w_onehot  = NREG'(1) << r_idx;
  assign w_tmr_clr = (r_state != S_REQ) | clear_req;
  assign w_tmr_inc = (r_state == S_REQ) & ~rd_ack;

  wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (w_tmr_clr),
    .inc     (w_tmr_inc),
    .expired (w_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_cap    <= '0;
      r_addr   <= '0;
      r_rd_req <= 1'b0;
      r_en     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_clr    <= 1'b0;
      r_err    <= 1'b0;
    end else if (clear_req) begin
      // err is deliberately left alone: only an accepted start clears it.
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_rd_req <= 1'b0;
      r_en     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_clr    <= 1'b0;
    end else begin
      r_en   <= '0;
      r_done <= 1'b0;
      r_clr  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state  <= S_REQ;
            r_idx    <= '0;
            r_err    <= 1'b0;
            r_rd_req <= 1'b1;
            r_addr   <= BASE_ADDR;
            r_busy   <= 1'b1;
          end
        end
        S_REQ: begin
          if (rd_ack) begin
            r_state  <= S_LOAD;
            r_cap    <= data_in;
            r_rd_req <= 1'b0;
            r_en     <= w_onehot;
          end else if (w_expired) begin
            r_state  <= S_ERR;
            r_rd_req <= 1'b0;
            r_clr    <= 1'b1;
            r_err    <= 1'b1;
          end
        end
        S_LOAD: begin
          if (r_idx == IDX_W'(NREG - 1)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state  <= S_REQ;
            r_idx    <= w_idx_inc;
            r_rd_req <= 1'b1;
            r_addr   <= BASE_ADDR + 8'(w_idx_inc);
          end
        end
        S_DONE, S_ERR: begin
          r_state <= S_IDLE;
          r_idx   <= '0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // clear_req acts in its own cycle, so it masks the registered strobes directly.
  assign rd_req   = r_rd_req & ~clear_req;
  assign en       = clear_req ? '0 : r_en;
  assign clr      = r_clr | (clear_req & reset);
  assign addr     = r_addr;
  assign data_out = r_cap;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;

endmodule

// File: tb/tb_reg_load_ctrl.sv
// Directed and randomized checks of reg_load_ctrl against a per-cycle expected trace.
module tb_reg_load_ctrl;

  localparam int         NREG = 6;
  localparam int         TO   = 15;
  localparam logic [7:0] BASE = 8'h00;

  logic            clk = 1'b0;
  logic            reset, start, clear_req, rd_ack;
  logic [7:0]      data_in;
  logic            rd_req, clr, busy, done, err;
  logic [7:0]      addr, data_out;
  logic [NREG-1:0] en;

  reg_load_ctrl #(.NREG(NREG), .BASE_ADDR(BASE), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .clear_req(clear_req),
    .rd_ack(rd_ack), .data_in(data_in), .rd_req(rd_req), .addr(addr),
    .en(en), .data_out(data_out), .clr(clr), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            busy, rd_req, done, clr, err, is_req, ack;
    bit [7:0]      addr, dout, din;
    bit [NREG-1:0] en;
  } step_t;

  step_t      tr[$];
  int         dly[NREG];
  bit [7:0]   dat[NREG];
  int         req_pos[NREG];
  int         load_pos[NREG];
  int         n_tests = 0;
  int         n_fail  = 0;
  bit         err_model = 1'b0;

  // Expected cycle-by-cycle view of one load: register i waits dly[i] cycles
  // for its ack then loads for one cycle; a wait of TO or more aborts to ERR.
  function automatic void build();
    step_t s;
    tr.delete();
    for (int i = 0; i < NREG; i++) begin
      req_pos[i]  = -1;
      load_pos[i] = -1;
    end
    for (int i = 0; i < NREG; i++) begin
      req_pos[i] = tr.size();
      for (int c = 0; c < TO; c++) begin
        s = '{default: 0};
        s.busy = 1; s.rd_req = 1; s.addr = BASE + 8'(i); s.is_req = 1;
        s.ack = (c == dly[i]); s.din = dat[i];
        tr.push_back(s);
        if (s.ack) break;
      end
      if (dly[i] >= TO) begin
        s = '{default: 0};
        s.busy = 1; s.clr = 1; s.err = 1;
        tr.push_back(s);
        return;
      end
      s = '{default: 0};
      s.busy = 1; s.en = NREG'(1) << i; s.dout = dat[i];
      load_pos[i] = tr.size();
      tr.push_back(s);
    end
    s = '{default: 0};
    s.busy = 1; s.done = 1;
    tr.push_back(s);
  endfunction

  task automatic chk(input string tag, input step_t e);
    logic [26:0] o, x;
    o = {busy, rd_req, (e.rd_req ? addr : 8'h00), en, ((e.en != 0) ? data_out : 8'h00),
         done, clr, err};
    x = {e.busy, e.rd_req, (e.rd_req ? e.addr : 8'h00), e.en, ((e.en != 0) ? e.dout : 8'h00),
         e.done, e.clr, e.err};
    n_tests++;
    assert (o === x) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, x);
    end
  endtask

  task automatic chk_idle(input string tag, input bit clr_exp);
    step_t s;
    s = '{default: 0};
    s.err = err_model; s.clr = clr_exp;
    chk(tag, s);
  endtask

  // abort_kind: 0 none, 1 clear_req at abort_at, 2 reset at abort_at
  task automatic run(input string nm, input int abort_kind, input int abort_at, input int exp_done);
    step_t e;
    int    done_cyc;
    done_cyc = -1;
    build();
    @(negedge clk);
    start = 1; clear_req = 0; rd_ack = 1'($urandom); data_in = 8'($urandom);
    for (int k = 0; k < tr.size(); k++) begin
      @(negedge clk);
      e = tr[k];
      start   = ($urandom_range(0, 3) == 0);
      rd_ack  = e.is_req ? e.ack : 1'($urandom);
      data_in = e.ack ? e.din : 8'($urandom);
      if (abort_kind == 1 && k == abort_at) begin
        clear_req = 1;
        e.en = '0; e.rd_req = 0; e.clr = 1; e.err = err_model;
        #1 chk($sformatf("%s_clrreq[%0d]", nm, k), e);
        @(negedge clk);
        clear_req = 0; start = 0; rd_ack = 0;
        #1 chk_idle($sformatf("%s_after_clr", nm), 1'b0);
        return;
      end
      if (abort_kind == 2 && k == abort_at) begin
        reset = 0; start = 0;
        err_model = 0;
        #1 chk_idle($sformatf("%s_rst_now", nm), 1'b0);
        n_tests++;
        assert (data_out === 8'h00) else begin
          n_fail++;
          $error("FAIL %s_rst_dout: observed %h expected 00", nm, data_out);
        end
        @(negedge clk);
        reset = 1; rd_ack = 0;
        @(negedge clk);
        #1 chk_idle($sformatf("%s_rst_rel0", nm), 1'b0);
        @(negedge clk);
        #1 chk_idle($sformatf("%s_rst_rel1", nm), 1'b0);
        return;
      end
      #1 chk($sformatf("%s[%0d]", nm, k), e);
      if (done) done_cyc = k + 1;
    end
    err_model = tr[tr.size()-1].err;
    @(negedge clk);
    start = 0; rd_ack = 0;
    #1 chk_idle($sformatf("%s_idle", nm), 1'b0);
    if (exp_done > 0) begin
      n_tests++;
      assert (done_cyc === exp_done) else begin
        n_fail++;
        $error("FAIL %s_done_lat: observed %0d expected %0d", nm, done_cyc, exp_done);
      end
    end
  endtask

  initial begin
    reset = 0; start = 0; clear_req = 0; rd_ack = 0; data_in = 8'h00;
    @(negedge clk);
    #1 chk_idle("reset_state", 1'b0);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    #1 chk_idle("post_reset", 1'b0);

    // zero-wait load, data 10..15, done in cycle 2*NREG+1
    for (int i = 0; i < NREG; i++) begin dly[i] = 0; dat[i] = 8'h10 + 8'(i); end
    run("zero_wait", 0, -1, 2 * NREG + 1);

    // ack delayed 3 cycles on idx 2
    for (int i = 0; i < NREG; i++) begin dly[i] = (i == 2) ? 3 : 0; dat[i] = 8'($urandom); end
    run("delay3", 0, -1, 16);

    // no ack on idx 4: timeout, err sticky
    for (int i = 0; i < NREG; i++) begin dly[i] = (i == 4) ? TO : 0; dat[i] = 8'($urandom); end
    run("timeout", 0, -1, -1);
    repeat (3) begin
      @(negedge clk);
      #1 chk_idle("err_sticky", 1'b0);
    end

    // start with clear_req in IDLE: only the clear pulse, err unchanged
    @(negedge clk);
    start = 1; clear_req = 1;
    #1 chk_idle("start_clr_same", 1'b1);
    @(negedge clk);
    start = 0; clear_req = 0;
    #1 chk_idle("start_clr_after", 1'b0);

    // next accepted start clears err
    for (int i = 0; i < NREG; i++) begin dly[i] = $urandom_range(0, 2); dat[i] = 8'($urandom); end
    run("err_clear", 0, -1, -1);

    // clear_req during LOAD of idx 3
    for (int i = 0; i < NREG; i++) begin dly[i] = $urandom_range(0, 2); dat[i] = 8'($urandom); end
    build();
    run("clr_load3", 1, load_pos[3], -1);

    // reset in REQ of idx 1
    for (int i = 0; i < NREG; i++) begin dly[i] = 2; dat[i] = 8'($urandom); end
    build();
    run("rst_req", 2, req_pos[1] + 1, -1);

    // randomized loads, occasional timeouts
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < NREG; i++) begin
        dly[i] = ($urandom_range(0, 15) == 0) ? TO + $urandom_range(0, 2) : $urandom_range(0, 4);
        dat[i] = 8'($urandom);
      end
      run($sformatf("rand%0d", r), 0, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
